mean_sched: RTL and testbench

- Frame-level sequencer for the zone-mean datapath.
- Arms on vsync and gates the pixel stream into the mean calculator for exactly one frame's worth of active pixels.
- Waits for the calculator's done pulse, snapshots all zone means into a shadow bank, then drains them zone by zone to the LED driver over a valid/ready handshake.
- Sits between the video input stage and the mean calculator, and between the mean calculator and the LED driver.

---
 rtl/mean_sched.sv | 168 ++++++++++++++++
 tb/tb_mean_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mean_sched.sv
// mean_sched: frame-level sequencer for the zone-mean datapath.
// Arms on vsync, gates exactly PIX_PER_FRAME active pixels into the mean
// calculator, captures the zone means on mean_done into a shadow bank and
// drains them zone by zone over a valid/ready stream.
// Optional watchdog in WAIT_MEAN: define MEAN_SCHED_TMO_EN.
`timescale 1ns/1ps

module mean_sched #(
  parameter int unsigned ZONES         = 16,
  parameter int unsigned MW            = 4,
  parameter int unsigned PIX_PER_FRAME = 1024,
  parameter int unsigned TMO_CYC       = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       vsync,
  input  logic                       de_i,
  input  logic [23:0]                pix_i,
  output logic                       data_en,
  output logic [23:0]                data,
  input  logic                       mean_done,
  input  logic [ZONES*MW-1:0]        MeanR,
  input  logic [ZONES*MW-1:0]        MeanG,
  input  logic [ZONES*MW-1:0]        MeanB,
  output logic                       zone_valid,
  input  logic                       zone_ready,
  output logic [$clog2(ZONES)-1:0]   zone_idx,
  output logic [3*MW-1:0]            zone_rgb,
  output logic                       zone_err,
  output logic                       busy,
  output logic                       frame_done,
  output logic [7:0]                 frame_cnt,
  output logic                       err_tmo
);

  localparam int unsigned ZW = $clog2(ZONES);
  localparam int unsigned CW = $clog2(PIX_PER_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ACCUM,
    S_WAIT_MEAN,
    S_DRAIN
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_pix_cnt;
  logic [ZW-1:0]       r_zone;
  logic                r_bad;
  logic [ZONES*MW-1:0] r_sh_r;
  logic [ZONES*MW-1:0] r_sh_g;
  logic [ZONES*MW-1:0] r_sh_b;

  logic w_last_pix;
  logic w_accept;
  logic w_last_zone;
  logic w_tmo;

  assign w_last_pix  = (r_state == S_ACCUM) && de_i &&
                       (r_pix_cnt == CW'(PIX_PER_FRAME - 1));
  assign w_accept    = zone_valid && zone_ready;
  assign w_last_zone = w_accept && (r_zone == ZW'(ZONES - 1));

`ifdef MEAN_SCHED_TMO_EN
  localparam int unsigned TW = $clog2(TMO_CYC);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_err_tmo;

  assign w_tmo   = (r_state == S_WAIT_MEAN) && !mean_done &&
                   (r_tmo_cnt == TW'(TMO_CYC - 1));
  assign err_tmo = r_err_tmo;

  // Watchdog: count cycles spent in WAIT_MEAN; error flag is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_err_tmo <= 1'b0;
    end else begin
      if (r_state == S_WAIT_MEAN) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else                        r_tmo_cnt <= '0;
      if (w_tmo) r_err_tmo <= 1'b1;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign err_tmo = 1'b0;
`endif

  // Sequencer: frame arming, pixel gating, mean capture and zone drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pix_cnt  <= '0;
      r_zone     <= '0;
      r_bad      <= 1'b0;
      r_sh_r     <= '0;
      r_sh_g     <= '0;
      r_sh_b     <= '0;
      data_en    <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      data_en    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) r_state <= S_ARM;
        end
        S_ARM: begin
          if (vsync) begin
            r_pix_cnt <= '0;
            r_state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          data_en <= de_i;
          if (de_i) begin
            data      <= pix_i;
            r_pix_cnt <= r_pix_cnt + 1'b1;
          end
          // early vsync only marks the frame; counting continues so the
          // calculator still sees a full frame of pixels
          if (vsync) r_bad <= 1'b1;
          if (w_last_pix) r_state <= S_WAIT_MEAN;
        end
        S_WAIT_MEAN: begin
          if (mean_done) begin
            r_sh_r  <= MeanR;
            r_sh_g  <= MeanG;
            r_sh_b  <= MeanB;
            r_zone  <= '0;
            r_state <= S_DRAIN;
          end else if (w_tmo) begin
            // shadow bank left untouched: previous frame's means are re-sent
            r_bad   <= 1'b1;
            r_zone  <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_accept) begin
            r_zone <= r_zone + 1'b1;
            if (w_last_zone) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
              r_bad      <= 1'b0;
              r_state    <= en ? S_ARM : S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign zone_valid = (r_state == S_DRAIN);
  assign zone_idx   = r_zone;
  assign zone_err   = zone_valid && r_bad;
  assign zone_rgb   = zone_valid ? {r_sh_r[r_zone*MW +: MW],
                                    r_sh_g[r_zone*MW +: MW],
                                    r_sh_b[r_zone*MW +: MW]} : '0;

endmodule

// File: tb/tb_mean_sched.sv
// tb_mean_sched: randomized self-checking bench for mean_sched.
// Transaction-level model: pixels queued per frame, zone means per frame,
// completed-frame count. Timeout scenario runs when MEAN_SCHED_TMO_EN is set.
`timescale 1ns/1ps

module tb_mean_sched;

  localparam int unsigned ZONES = 16;
  localparam int unsigned MW    = 4;
  localparam int unsigned PPF   = 64;
  localparam int unsigned TMO   = 100;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     en = 1'b0;
  logic                     vsync = 1'b0;
  logic                     de_i = 1'b0;
  logic [23:0]              pix_i = '0;
  logic                     data_en;
  logic [23:0]              data;
  logic                     mean_done = 1'b0;
  logic [ZONES*MW-1:0]      mean_r = '0;
  logic [ZONES*MW-1:0]      mean_g = '0;
  logic [ZONES*MW-1:0]      mean_b = '0;
  logic                     zone_valid;
  logic                     zone_ready = 1'b0;
  logic [$clog2(ZONES)-1:0] zone_idx;
  logic [3*MW-1:0]          zone_rgb;
  logic                     zone_err;
  logic                     busy;
  logic                     frame_done;
  logic [7:0]               frame_cnt;
  logic                     err_tmo;

  mean_sched #(
    .ZONES         (ZONES),
    .MW            (MW),
    .PIX_PER_FRAME (PPF),
    .TMO_CYC       (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .vsync      (vsync),
    .de_i       (de_i),
    .pix_i      (pix_i),
    .data_en    (data_en),
    .data       (data),
    .mean_done  (mean_done),
    .MeanR      (mean_r),
    .MeanG      (mean_g),
    .MeanB      (mean_b),
    .zone_valid (zone_valid),
    .zone_ready (zone_ready),
    .zone_idx   (zone_idx),
    .zone_rgb   (zone_rgb),
    .zone_err   (zone_err),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_tmo    (err_tmo)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [23:0] exp_pix[$];
  int unsigned de_seen = 0;
  int unsigned exp_r[ZONES];
  int unsigned exp_g[ZONES];
  int unsigned exp_b[ZONES];
  logic [7:0]  frames = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rgb(input int unsigned z);
    return (exp_r[z] << (2*MW)) | (exp_g[z] << MW) | exp_b[z];
  endfunction

  task automatic garbage_means();
    for (int unsigned z = 0; z < ZONES; z++) begin
      mean_r[z*MW +: MW] = MW'($urandom);
      mean_g[z*MW +: MW] = MW'($urandom);
      mean_b[z*MW +: MW] = MW'($urandom);
    end
  endtask

  task automatic rst_checks(input string tag);
    check_eq({tag, "_data_en"},    data_en, 0);
    check_eq({tag, "_data"},       data, 0);
    check_eq({tag, "_zone_valid"}, zone_valid, 0);
    check_eq({tag, "_zone_idx"},   zone_idx, 0);
    check_eq({tag, "_zone_rgb"},   zone_rgb, 0);
    check_eq({tag, "_zone_err"},   zone_err, 0);
    check_eq({tag, "_busy"},       busy, 0);
    check_eq({tag, "_frame_done"}, frame_done, 0);
    check_eq({tag, "_frame_cnt"},  frame_cnt, 0);
    check_eq({tag, "_err_tmo"},    err_tmo, 0);
  endtask

  // Every forwarded pixel must be the next one the model expects
  always @(negedge clk) begin
    if (data_en) begin
      de_seen++;
      if (exp_pix.size() == 0) check_eq("data_en_unexpected", data_en, 0);
      else                     check_eq("data", data, exp_pix.pop_front());
    end
  end

  // Random-gap pixels; pixel number bad_at carries a second vsync
  task automatic send_pix(input int n, input int bad_at, input bit spurious, input bit drop_en);
    int fwd = 0;
    while (fwd < n) begin
      de_i      = ($urandom_range(3) != 0);
      pix_i     = 24'($urandom);
      vsync     = de_i && (bad_at >= 0) && (fwd == bad_at);
      mean_done = spurious && (fwd == 10);
      garbage_means();
      if (drop_en && fwd == 20) en = 1'b0;
      if (de_i) begin
        exp_pix.push_back(pix_i);
        fwd++;
      end
      tick();
    end
    de_i      = 1'b0;
    vsync     = 1'b0;
    mean_done = 1'b0;
  endtask

  task automatic drain(input int rmode, input bit inject, input bit exp_err);
    int unsigned beat = 0;
    int unsigned cyc  = 0;
    bit rdy;
    bit tog = 1'b0;
    while (beat < ZONES && cyc < 200) begin
      check_eq("zone_valid", zone_valid, 1);
      check_eq("zone_idx", zone_idx, beat);
      check_eq("zone_rgb", zone_rgb, exp_rgb(beat));
      check_eq("zone_err", zone_err, exp_err);
      check_eq("frame_done_early", frame_done, 0);
      case (rmode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = ~tog; end
        default: rdy = ($urandom_range(1) == 1);
      endcase
      zone_ready = rdy;
      if (inject) begin
        de_i  = ($urandom_range(1) == 1);
        pix_i = 24'($urandom);
        vsync = (cyc == 3);
      end
      tick();
      cyc++;
      if (rdy) beat++;
    end
    zone_ready = 1'b0;
    de_i       = 1'b0;
    vsync      = 1'b0;
    frames     = frames + 8'd1;
    check_eq("beats", beat, ZONES);
    check_eq("frame_done", frame_done, 1);
    check_eq("zone_valid_after", zone_valid, 0);
    check_eq("frame_cnt", frame_cnt, frames);
    tick();
    check_eq("frame_done_pulse", frame_done, 0);
  endtask

  task automatic run_frame(input int bad_at, input int rmode, input bit inject,
                           input bit plan, input bit spurious, input bit drop_en);
    de_seen = 0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    send_pix(PPF, bad_at, spurious, drop_en);
    // calculator busy: stray pixels and a vsync must be dropped
    for (int k = 0; k < 6; k++) begin
      de_i  = 1'b1;
      pix_i = 24'($urandom);
      vsync = (k == 2);
      tick();
    end
    de_i  = 1'b0;
    vsync = 1'b0;
    check_eq("de_count", de_seen, PPF);
    check_eq("busy_wait", busy, 1);
    for (int unsigned z = 0; z < ZONES; z++) begin
      exp_r[z] = plan ? z              : $urandom_range(15);
      exp_g[z] = plan ? (15 - z)       : $urandom_range(15);
      exp_b[z] = plan ? 5              : $urandom_range(15);
      mean_r[z*MW +: MW] = MW'(exp_r[z]);
      mean_g[z*MW +: MW] = MW'(exp_g[z]);
      mean_b[z*MW +: MW] = MW'(exp_b[z]);
    end
    mean_done = 1'b1;
    tick();
    mean_done = 1'b0;
    garbage_means();
    drain(rmode, inject, bad_at >= 0);
    check_eq("busy_end", busy, en);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim_time_limit");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int unsigned n;

    repeat (3) tick();
    rst_checks("rst0");
    rst = 1'b0;
    en  = 1'b1;
    tick();
    tick();

    run_frame(-1, 0, 1'b0, 1'b1, 1'b0, 1'b0);  // reference pattern, always ready
    run_frame(-1, 1, 1'b0, 1'b1, 1'b1, 1'b0);  // ready toggling, stray mean_done
    run_frame(40, 2, 1'b0, 1'b0, 1'b0, 1'b0);  // early vsync -> zone_err
    run_frame(-1, 2, 1'b1, 1'b0, 1'b0, 1'b0);  // clean, traffic during drain
    run_frame(-1, 2, 1'b0, 1'b0, 1'b0, 1'b1);  // en dropped mid-frame

    for (int k = 0; k < 8; k++) begin
      vsync = (k == 1);
      de_i  = 1'b1;
      pix_i = 24'($urandom);
      tick();
      check_eq("idle_busy", busy, 0);
    end
    vsync = 1'b0;
    de_i  = 1'b0;
    en    = 1'b1;
    tick();
    tick();

    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    send_pix(30, -1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst_checks("rst_mid");
    check_eq("rst_queue_empty", exp_pix.size(), 0);
    rst    = 1'b0;
    frames = '0;
    tick();
    tick();
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 3; f++) begin
      run_frame(($urandom_range(2) == 0) ? int'($urandom_range(PPF - 2, 1)) : -1,
                2, ($urandom_range(1) == 1), 1'b0, ($urandom_range(1) == 1), 1'b0);
    end

`ifdef MEAN_SCHED_TMO_EN
    de_seen = 0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    send_pix(PPF, -1, 1'b0, 1'b0);
    n = 0;
    while (!zone_valid && n < 400) begin
      check_eq("err_tmo_early", err_tmo, 0);
      tick();
      n++;
    end
    check_eq("tmo_cycles", n, TMO);
    check_eq("err_tmo_set", err_tmo, 1);
    drain(0, 1'b0, 1'b1);
    check_eq("err_tmo_sticky", err_tmo, 1);
`else
    n = 0;
    check_eq("err_tmo_tied", err_tmo, n);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
